// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-operand forwarding selects and load-use stall detection
module fwd_hazard_unit #(
  parameter int RA_W        = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [RA_W-1:0]        id_rs,
  input  logic [RA_W-1:0]        id_rt,
  input  logic                   id_uses_rt,
  input  logic [RA_W-1:0]        id_dest,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic [RA_W-1:0] ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic            ex_rw, ex_mr, mem_rw, wb_rw, adv;
  // a load in EX whose destination feeds a live source of the ID instruction
  always_comb stall = ex_mr && ex_dest != '0 &&
                      (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
  // ID moves into EX only when neither stalled nor squashed
  always_comb adv = !stall && !flush;
  // operand A: newest producer (EX/MEM) wins over MEM/WB; $zero never forwarded
  always_comb fwd_a_sel = (mem_rw && mem_dest != '0 && mem_dest == ex_rs) ? 2'b01 :
                          (wb_rw && wb_dest != '0 && wb_dest == ex_rs)    ? 2'b10 : 2'b00;
  // operand B: same priority on rt
  always_comb fwd_b_sel = (mem_rw && mem_dest != '0 && mem_dest == ex_rt) ? 2'b01 :
                          (wb_rw && wb_dest != '0 && wb_dest == ex_rt)    ? 2'b10 : 2'b00;
  // pipeline tracking; a blocked ID slot becomes a bubble in EX
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dest  <= '0;
      ex_rw    <= 1'b0;
      ex_mr    <= 1'b0;
      mem_dest <= '0;
      mem_rw   <= 1'b0;
      wb_dest  <= '0;
      wb_rw    <= 1'b0;
    end else begin
      ex_rs    <= adv ? id_rs : '0;
      ex_rt    <= adv ? id_rt : '0;
      ex_dest  <= adv ? id_dest : '0;
      ex_rw    <= adv && id_reg_write;
      ex_mr    <= adv && id_mem_read;
      mem_dest <= ex_dest;
      mem_rw   <= ex_rw;
      wb_dest  <= mem_dest;
      wb_rw    <= mem_rw;
    end
  // saturating count of stalled cycles
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Tracks destination-register state through the ID/EX, EX/MEM and MEM/WB pipeline stages.
- Drives the 2-bit select inputs of the two 32-bit 3:1 ALU-operand forwarding muxes.
- Detects load-use hazards, requests a one-cycle pipeline stall and inserts a bubble into EX.
- Sits between the decode stage and the EX-stage operand muxes.

Parameters:
- RA_W, 5, register-address width.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- id_rs  in  RA_W  rs field of the instruction in ID.
- id_rt  in  RA_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_dest  in  RA_W  destination register of the ID instruction (rd or rt, already resolved).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  branch/jump taken; squash the ID instruction.
- fwd_a_sel  out  2  operand-A mux select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b_sel  out  2  operand-B mux select, same encoding.
- stall  out  1  hold PC and IF/ID this cycle.
- stall_count  out  STALL_CNT_W  number of stall cycles since reset.

Behaviour:
- State registers:
  - EX: ex_rs, ex_rt, ex_dest, ex_rw, ex_mr.
  - MEM: mem_dest, mem_rw.
  - WB: wb_dest, wb_rw.
- Reset (asynchronous): all rw/mr bits 0, all address fields 0, stall_count 0. Outputs immediately read fwd_a_sel=00, fwd_b_sel=00, stall=0.
- Each rising edge, MEM←EX and WB←MEM unconditionally.
- EX←ID when stall=0 and flush=0. Otherwise EX loads a bubble: ex_rw=0, ex_mr=0, address fields 0.
- stall is combinational and equals ex_mr & (ex_dest≠0) & ((ex_dest==id_rs) | (id_uses_rt & ex_dest==id_rt)).
- flush and stall asserted together: a bubble is inserted; stall is still reported.
- fwd_a_sel is combinational from registered state only:
  - 01 if mem_rw & mem_dest≠0 & mem_dest==ex_rs;
  - else 10 if wb_rw & wb_dest≠0 & wb_dest==ex_rs;
  - else 00.
- fwd_b_sel uses the same rule on ex_rt.
- The EX/MEM source has priority over MEM/WB (newest value wins). Register 0 is never forwarded. Code 11 is never driven.
- Latency: a producer in EX at cycle t is forwarded (sel=01) to the dependent instruction in EX at t+1, and as sel=10 at t+2. At t+3 the register file supplies the value (write-before-read regfile), so sel=00.
- Load-use: a load in EX with a dependent instruction in ID gives stall=1 for exactly one cycle. The dependent instruction then reaches EX with sel=10 for that operand.
- stall_count increments on every cycle with stall=1 and saturates at all-ones (no wrap).
- Reset asserted mid-operation: all in-flight state is discarded at once, with no partial drain.

Test Plan:
- Reset: Rst=1 for 2 cycles with random inputs -> sels 00, stall 0, stall_count 0 throughout, including asynchronously mid-cycle.
- EX-EX forward: ID add $8 (dest 8, rw) then ID sub with rs=8 next cycle -> when sub is in EX, fwd_a_sel=01, fwd_b_sel=00.
- MEM-WB forward and priority: writes to $9 at t and t+1, reader rs=rt=9 at t+2 -> fwd_a_sel=fwd_b_sel=01. With only the t write present -> both 10.
- $zero: producer dest=0 with rw=1, reader rs=0 -> fwd_a_sel=00. Load with dest 0 followed by a reader of 0 -> stall=0.
- Load-use: lw dest 10 in EX, ID rs=10 -> stall=1 for one cycle, stall_count 0→1, bubble in EX. Next cycle the dependent instruction is in EX with fwd_a_sel=10. Repeat with id_uses_rt=0 and rt=10 -> no stall.
- Flush: flush=1 with a producer in ID -> EX gets a bubble. A subsequent reader of that register sees sel=00. Force 65540 stalls -> stall_count holds 0xFFFF.
